hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter BRANCH_FLUSH_CYC, default 1, SHALL set the number of cycles IF/ID is flushed per taken branch/jump (legal range 1..3).
REQ-002 Parameter DMEM_TIMEOUT, default 15, SHALL set the maximum number of consecutive MEM_WAIT cycles before error (legal range 2..255).
REQ-003 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 idex_memread_i  in  1  instruction in EX is a load.
REQ-006 idex_rt_i  in  5  load destination register in EX.
REQ-007 ifid_rs_i, ifid_rt_i  in  5 each  source registers of the instruction in ID.
REQ-008 branch_taken_i  in  1  branch or jump resolved taken in ID this cycle.
REQ-009 dmem_req_i  in  1  MEM stage holds a load/store this cycle.
REQ-010 dmem_ready_i  in  1  data memory completes the MEM-stage access this cycle.
REQ-011 pc_write_o  out  1  1 = PC updates.
REQ-012 ifid_write_o  out  1  1 = IF/ID latches.
REQ-013 ifid_flush_o  out  1  1 = IF/ID loads a bubble.
REQ-014 idex_ctrl_pass_o  out  1  drives the ID/EX control-bubble mux: 1 = pass decoded WB/EX/MEM controls, 0 = zero them.
REQ-015 pipe_hold_o  out  1  1 = ID/EX, EX/MEM and MEM/WB hold their contents.
REQ-016 state_o  out  2  current state encoding.
REQ-017 err_o  out  1  sticky memory-timeout error.
REQ-018 stall_cnt_o, flush_cnt_o, memwait_cnt_o  out  16 each  performance counters.

Function
REQ-019 States SHALL be RUN=2'd0, FLUSH=2'd1, MEM_WAIT=2'd2, ERR=2'd3; all controls other than state, counters and err_o are combinational from state and inputs (zero-latency).
REQ-020 Default (no event) SHALL be pc_write_o=1, ifid_write_o=1, ifid_flush_o=0, idex_ctrl_pass_o=1, pipe_hold_o=0.
REQ-021 Load-use hazard SHALL be idex_memread_i && idex_rt_i!=0 && (idex_rt_i==ifid_rs_i || idex_rt_i==ifid_rt_i).
REQ-022 Priority in RUN SHALL be memory hold > load-use > branch.
REQ-023 RUN with dmem_req_i=1, dmem_ready_i=0: all five control outputs take hold values (pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_ctrl_pass_o=1, pipe_hold_o=1); next state MEM_WAIT, wait counter=1.
REQ-024 RUN with load-use and no memory hold: pc_write_o=0, ifid_write_o=0, idex_ctrl_pass_o=0, ifid_flush_o=0 for exactly that cycle; state stays RUN; branch_taken_i ignored.
REQ-025 RUN with branch_taken_i, no hold, no load-use: ifid_flush_o=1, pc_write_o=1; next state FLUSH with counter=BRANCH_FLUSH_CYC-1 if BRANCH_FLUSH_CYC>1, else RUN.
REQ-026 FLUSH: ifid_flush_o=1, pc_write_o=1; counter decrements each cycle; return to RUN on the cycle counter reaches 1; branch_taken_i and load-use ignored.
REQ-027 A memory hold arising in FLUSH SHALL apply REQ-023 outputs, freeze the flush counter and resume FLUSH after ready.
REQ-028 MEM_WAIT: outputs as REQ-023 while dmem_ready_i=0; on dmem_ready_i=1 outputs return to default that same cycle and state returns to RUN (or FLUSH if entered from FLUSH); branch and load-use ignored.
REQ-029 MEM_WAIT wait counter SHALL increment each cycle with dmem_ready_i=0; on reaching DMEM_TIMEOUT the next state is ERR.
REQ-030 ERR: hold outputs of REQ-023, err_o=1; exit only by reset.

Reset
REQ-031 While rst_i=1: state RUN, err_o=0, wait/flush counters 0, perf counters 0; pc_write_o=0, ifid_write_o=0, ifid_flush_o=1, idex_ctrl_pass_o=0, pipe_hold_o=0.
REQ-032 Reset asserted in any state (including mid-MEM_WAIT or FLUSH) SHALL take effect on the next edge with no residual hold.

Configuration
REQ-033 Macro HAZARD_CTRL_PERF_CNT_EN defined: stall_cnt_o counts load-use cycles, flush_cnt_o counts cycles with ifid_flush_o=1 (excluding reset), memwait_cnt_o counts MEM_WAIT cycles; all 16-bit, saturate at 16'hFFFF.
REQ-034 Macro undefined: ports remain, driven constant 0, no counter registers.

Verification
REQ-035 Load in EX rt=5, ID rs=5 -> one cycle pc_write_o=0, idex_ctrl_pass_o=0; next cycle defaults; stall_cnt_o=1.
REQ-036 Load rt=0 matching ID rs=0 -> no stall.
REQ-037 BRANCH_FLUSH_CYC=3, branch_taken_i pulse -> ifid_flush_o=1 for exactly 3 cycles, state_o 0->1->1->0.
REQ-038 dmem_req_i=1, dmem_ready_i low 4 cycles then high -> pipe_hold_o=1 for 4 cycles, 0 on 5th, memwait_cnt_o=3 (cycles in MEM_WAIT).
REQ-039 DMEM_TIMEOUT=4, ready never asserted -> state_o=3 and err_o=1 after 4 MEM_WAIT cycles; rst_i pulse -> RUN, err_o=0.
REQ-040 Branch and load-use same cycle -> stall wins, ifid_flush_o=0; branch re-presented next cycle -> flush.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and data-memory wait handling.
// Optional performance counters are enabled by defining HAZARD_CTRL_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int BRANCH_FLUSH_CYC = 1,
  parameter int DMEM_TIMEOUT     = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        idex_memread_i,
  input  logic [4:0]  idex_rt_i,
  input  logic [4:0]  ifid_rs_i,
  input  logic [4:0]  ifid_rt_i,
  input  logic        branch_taken_i,
  input  logic        dmem_req_i,
  input  logic        dmem_ready_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        idex_ctrl_pass_o,
  output logic        pipe_hold_o,
  output logic [1:0]  state_o,
  output logic        err_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o,
  output logic [15:0] memwait_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERR      = 2'd3
  } state_e;

  localparam logic [1:0] FLUSH_INIT = 2'(BRANCH_FLUSH_CYC - 1);
  localparam logic [7:0] TIMEOUT    = 8'(DMEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [1:0] flush_left_q, flush_left_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       ret_flush_q, ret_flush_d;
  logic       err_q, err_d;

  logic mem_hold;
  logic load_use;
  logic load_use_stall;
  logic memwait_stall;

  assign mem_hold = dmem_req_i && !dmem_ready_i;
  assign load_use = idex_memread_i && (idex_rt_i != 5'd0) &&
                    ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

  always_comb begin
    state_d          = state_q;
    flush_left_d     = flush_left_q;
    wait_cnt_d       = wait_cnt_q;
    ret_flush_d      = ret_flush_q;
    err_d            = err_q;
    pc_write_o       = 1'b1;
    ifid_write_o     = 1'b1;
    ifid_flush_o     = 1'b0;
    idex_ctrl_pass_o = 1'b1;
    pipe_hold_o      = 1'b0;
    load_use_stall   = 1'b0;
    memwait_stall    = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mem_hold) begin
          pc_write_o   = 1'b0;
          ifid_write_o = 1'b0;
          pipe_hold_o  = 1'b1;
          state_d      = ST_MEM_WAIT;
          wait_cnt_d   = 8'd1;
          ret_flush_d  = 1'b0;
        end else if (load_use) begin
          pc_write_o       = 1'b0;
          ifid_write_o     = 1'b0;
          idex_ctrl_pass_o = 1'b0;
          load_use_stall   = 1'b1;
        end else if (branch_taken_i) begin
          ifid_flush_o = 1'b1;
          if (BRANCH_FLUSH_CYC > 1) begin
            state_d      = ST_FLUSH;
            flush_left_d = FLUSH_INIT;
          end
        end
      end

      ST_FLUSH: begin
        // A memory hold parks the remaining flush count until the access completes.
        if (mem_hold) begin
          pc_write_o   = 1'b0;
          ifid_write_o = 1'b0;
          pipe_hold_o  = 1'b1;
          state_d      = ST_MEM_WAIT;
          wait_cnt_d   = 8'd1;
          ret_flush_d  = 1'b1;
        end else begin
          ifid_flush_o = 1'b1;
          if (flush_left_q <= 2'd1) begin
            state_d      = ST_RUN;
            flush_left_d = 2'd0;
          end else begin
            flush_left_d = flush_left_q - 2'd1;
          end
        end
      end

      ST_MEM_WAIT: begin
        if (dmem_ready_i) begin
          state_d     = ret_flush_q ? ST_FLUSH : ST_RUN;
          wait_cnt_d  = 8'd0;
          ret_flush_d = 1'b0;
        end else begin
          pc_write_o    = 1'b0;
          ifid_write_o  = 1'b0;
          pipe_hold_o   = 1'b1;
          memwait_stall = 1'b1;
          if (wait_cnt_q >= TIMEOUT) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end

      default: begin
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
        pipe_hold_o  = 1'b1;
        err_d        = 1'b1;
      end
    endcase

    if (rst_i) begin
      pc_write_o       = 1'b0;
      ifid_write_o     = 1'b0;
      ifid_flush_o     = 1'b1;
      idex_ctrl_pass_o = 1'b0;
      pipe_hold_o      = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_RUN;
      flush_left_q <= 2'd0;
      wait_cnt_q   <= 8'd0;
      ret_flush_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_left_q <= flush_left_d;
      wait_cnt_q   <= wait_cnt_d;
      ret_flush_q  <= ret_flush_d;
      err_q        <= err_d;
    end
  end

  assign state_o = state_q;
  assign err_o   = err_q;

`ifdef HAZARD_CTRL_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [15:0] memwait_cnt_q, memwait_cnt_d;

  // Saturating event counters; the reset cycle itself is never counted.
  always_comb begin
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    memwait_cnt_d = memwait_cnt_q;
    if (load_use_stall && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (ifid_flush_o && (flush_cnt_q != 16'hFFFF))
      flush_cnt_d = flush_cnt_q + 16'd1;
    if (memwait_stall && (memwait_cnt_q != 16'hFFFF))
      memwait_cnt_d = memwait_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q   <= 16'd0;
      flush_cnt_q   <= 16'd0;
      memwait_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      memwait_cnt_q <= memwait_cnt_d;
    end
  end

  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;
  assign memwait_cnt_o = memwait_cnt_q;
`else
  logic unused_perf_events;
  assign unused_perf_events = load_use_stall ^ memwait_stall;

  assign stall_cnt_o   = 16'd0;
  assign flush_cnt_o   = 16'd0;
  assign memwait_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (BRANCH_FLUSH_CYC=3, DMEM_TIMEOUT=4).
module tb_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        idex_memread_i;
  logic [4:0]  idex_rt_i, ifid_rs_i, ifid_rt_i;
  logic        branch_taken_i, dmem_req_i, dmem_ready_i;
  logic        pc_write_o, ifid_write_o, ifid_flush_o, idex_ctrl_pass_o, pipe_hold_o;
  logic [1:0]  state_o;
  logic        err_o;
  logic [15:0] stall_cnt_o, flush_cnt_o, memwait_cnt_o;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] S_RUN = 2'd0, S_FLUSH = 2'd1, S_MW = 2'd2, S_ERR = 2'd3;

  // Control vectors ordered {pc_write, ifid_write, ifid_flush, idex_ctrl_pass, pipe_hold}
  localparam logic [4:0] C_DEF   = 5'b11010;
  localparam logic [4:0] C_STALL = 5'b00000;
  localparam logic [4:0] C_FLUSH = 5'b11110;
  localparam logic [4:0] C_HOLD  = 5'b00011;
  localparam logic [4:0] C_RST   = 5'b00100;

`ifdef HAZARD_CTRL_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  hazard_ctrl #(
    .BRANCH_FLUSH_CYC(3),
    .DMEM_TIMEOUT    (4)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .idex_memread_i  (idex_memread_i),
    .idex_rt_i       (idex_rt_i),
    .ifid_rs_i       (ifid_rs_i),
    .ifid_rt_i       (ifid_rt_i),
    .branch_taken_i  (branch_taken_i),
    .dmem_req_i      (dmem_req_i),
    .dmem_ready_i    (dmem_ready_i),
    .pc_write_o      (pc_write_o),
    .ifid_write_o    (ifid_write_o),
    .ifid_flush_o    (ifid_flush_o),
    .idex_ctrl_pass_o(idex_ctrl_pass_o),
    .pipe_hold_o     (pipe_hold_o),
    .state_o         (state_o),
    .err_o           (err_o),
    .stall_cnt_o     (stall_cnt_o),
    .flush_cnt_o     (flush_cnt_o),
    .memwait_cnt_o   (memwait_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [15:0] perf(input int n);
    return PERF_EN ? 16'(n) : 16'd0;
  endfunction

  task automatic applyStimulus(input logic memread, input logic [4:0] ex_rt,
                               input logic [4:0] id_rs, input logic [4:0] id_rt,
                               input logic branch, input logic req, input logic ready,
                               input logic rst);
    idex_memread_i = memread;
    idex_rt_i      = ex_rt;
    ifid_rs_i      = id_rs;
    ifid_rt_i      = id_rt;
    branch_taken_i = branch;
    dmem_req_i     = req;
    dmem_ready_i   = ready;
    rst_i          = rst;
  endtask

  // Waits for the mid-cycle falling edge, then compares controls, state and error flag.
  task automatic checkOutput(input string tag, input logic [4:0] ctrl,
                             input logic [1:0] st, input logic err);
    logic [7:0] observed, expected;
    @(negedge clk_i);
    observed = {pc_write_o, ifid_write_o, ifid_flush_o, idex_ctrl_pass_o, pipe_hold_o,
                state_o, err_o};
    expected = {ctrl, st, err};
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic checkCounters(input string tag, input int stall, input int flush,
                               input int memwait);
    logic [47:0] observed, expected;
    observed = {stall_cnt_o, flush_cnt_o, memwait_cnt_o};
    expected = {perf(stall), perf(flush), perf(memwait)};
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic advance();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    advance();
    checkOutput("reset", C_RST, S_RUN, 0);
    checkCounters("reset_cnt", 0, 0, 0);
    advance();

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("default", C_DEF, S_RUN, 0);
    advance();

    // Load-use detection
    applyStimulus(1, 5, 5, 0, 0, 0, 0, 0);
    checkOutput("load_use_rs", C_STALL, S_RUN, 0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("after_stall", C_DEF, S_RUN, 0);
    checkCounters("stall_cnt_1", 1, 0, 0);
    advance();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("load_rt0", C_DEF, S_RUN, 0);
    advance();
    applyStimulus(1, 7, 3, 7, 0, 0, 0, 0);
    checkOutput("load_use_rt", C_STALL, S_RUN, 0);
    advance();
    applyStimulus(0, 5, 5, 5, 0, 0, 0, 0);
    checkOutput("no_memread", C_DEF, S_RUN, 0);
    advance();

    // Stall beats branch, then a 3-cycle flush
    applyStimulus(1, 9, 9, 0, 1, 0, 0, 0);
    checkOutput("stall_beats_branch", C_STALL, S_RUN, 0);
    advance();
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("branch_flush", C_FLUSH, S_RUN, 0);
    advance();
    applyStimulus(1, 4, 4, 0, 1, 0, 0, 0);
    checkOutput("flush_1", C_FLUSH, S_FLUSH, 0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("flush_2", C_FLUSH, S_FLUSH, 0);
    advance();
    checkOutput("flush_done", C_DEF, S_RUN, 0);
    checkCounters("cnt_after_flush", 3, 3, 0);
    advance();

    // Memory wait: ready low 4 cycles, then high
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("mem_hold_run", C_HOLD, S_RUN, 0);
    advance();
    checkOutput("mem_wait_1", C_HOLD, S_MW, 0);
    advance();
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 0);
    checkOutput("mem_wait_branch", C_HOLD, S_MW, 0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("mem_wait_3", C_HOLD, S_MW, 0);
    advance();
    applyStimulus(1, 6, 6, 0, 1, 1, 1, 0);
    checkOutput("mem_ready", C_DEF, S_MW, 0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("mem_done", C_DEF, S_RUN, 0);
    checkCounters("cnt_after_mem", 3, 3, 3);
    advance();

    // Memory hold during a flush freezes and then resumes it
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("branch2", C_FLUSH, S_RUN, 0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("flush_mem_hold", C_HOLD, S_FLUSH, 0);
    advance();
    checkOutput("flush_mw", C_HOLD, S_MW, 0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 0);
    checkOutput("flush_mw_ready", C_DEF, S_MW, 0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("flush_resume_1", C_FLUSH, S_FLUSH, 0);
    advance();
    checkOutput("flush_resume_2", C_FLUSH, S_FLUSH, 0);
    advance();
    checkOutput("flush_resume_done", C_DEF, S_RUN, 0);
    checkCounters("cnt_after_flush_mem", 3, 6, 4);
    advance();

    // Timeout into the sticky error state
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("to_run", C_HOLD, S_RUN, 0);
    advance();
    for (int i = 0; i < 4; i++) begin
      checkOutput("to_wait", C_HOLD, S_MW, 0);
      advance();
    end
    checkOutput("to_err", C_HOLD, S_ERR, 1);
    advance();
    applyStimulus(0, 0, 0, 0, 1, 1, 1, 0);
    checkOutput("err_sticky", C_HOLD, S_ERR, 1);
    checkCounters("cnt_in_err", 3, 6, 8);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("rst_in_err", C_RST, S_ERR, 1);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("after_err_rst", C_DEF, S_RUN, 0);
    checkCounters("cnt_after_rst", 0, 0, 0);
    advance();

    // Reset mid-MEM_WAIT and mid-FLUSH leaves no residual hold
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("mw_rst_a", C_HOLD, S_RUN, 0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 1);
    checkOutput("mw_rst_b", C_RST, S_MW, 0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("mw_rst_c", C_DEF, S_RUN, 0);
    advance();
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("fr_a", C_FLUSH, S_RUN, 0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("fr_b", C_RST, S_FLUSH, 0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("fr_c", C_DEF, S_RUN, 0);
    checkCounters("cnt_final", 0, 0, 0);
    advance();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
